// File: rtl/hawk_cmpresn_ctrl.sv
// HAWK compression manager: pops the uncompressed-list head, streams the page
// to the compressor, places the result via PWM and frees the way.
module hawk_cmpresn_ctrl #(
  parameter int unsigned   AW       = 64,
  parameter int unsigned   DW       = 512,
  parameter int unsigned   LW       = 16,
  parameter logic [AW-1:0] TOL_BASE = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           trigger,
  input  logic [LW-1:0]  uncomp_head,
  input  logic [LW-1:0]  uncomp_tail,
  input  logic           arready,
  output logic           arvalid,
  output logic [AW-1:0]  araddr,
  output logic [7:0]     arlen,
  input  logic           rvalid,
  input  logic           rlast,
  input  logic [1:0]     rresp,
  input  logic [DW-1:0]  rdata,
  output logic           rready,
  input  logic           rdfifo_full,
  output logic           rdm_reset,
  output logic           comp_start,
  input  logic           comp_done,
  input  logic           incompressible,
  input  logic [13:0]    comp_size,
  input  logic           pwm_ready,
  output logic           zspg_req,
  output logic [AW-13:0] zspg_way,
  output logic [13:0]    zspg_size,
  input  logic           zspg_updated,
  input  logic [AW-1:0]  zspg_cpage,
  output logic           tbl_update,
  output logic [15:0]    upd_att_id,
  output logic [1:0]     upd_sts,
  output logic [AW-1:0]  upd_ppa,
  output logic [LW-1:0]  upd_lst_id,
  input  logic           tbl_update_done,
  output logic           done,
  output logic           fail,
  output logic [AW-13:0] free_way
);

  localparam int unsigned WW = AW - 12;
  localparam logic [1:0] ST_INCOMP = 2'd2;
  localparam logic [1:0] ST_COMP   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_RD_REQ, S_RD_WAIT, S_RDM_RST, S_PG_REQ, S_PG_STRM,
    S_WAIT_COMP, S_ZS_REQ, S_ZS_WAIT, S_TBL_REQ, S_TBL_WAIT, S_HOLD, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   id_q;
  logic [2:0]      sel_q;
  logic [WW-1:0]   way_q;
  logic [15:0]     att_q;
  logic [5:0]      cnt_q;
  logic            pend_q, pinc_q;
  logic [13:0]     psz_q;
  logic            rd_en_q, strm_q;
  logic            done_d, fail_d;
  logic            beat, cd, cinc;
  logic [13:0]     csz;
  logic [AW-1:0]   tol_addr;
  logic [63:0]     tol_word;

  assign tol_addr = TOL_BASE + ((AW'(uncomp_head) - AW'(1)) << 3);
  assign tol_word = rdata[{sel_q, 6'b0} +: 64];
  // FIFO full gates R ready combinationally so no beat is ever dropped
  assign rready   = rd_en_q & ~(strm_q & rdfifo_full);
  assign beat     = rvalid & rready;
  assign cd       = comp_done | pend_q;
  assign cinc     = pend_q ? pinc_q : incompressible;
  assign csz      = pend_q ? psz_q : comp_size;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      S_IDLE:    if (trigger) state_d = S_POP;
      S_POP: begin
        if (uncomp_head == '0) begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (arready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (beat) begin
          if (rresp != 2'b00) state_d = S_ERR;
          else if (rlast)     state_d = S_RDM_RST;
        end
      end
      S_RDM_RST: state_d = S_PG_REQ;
      S_PG_REQ:  if (arready) state_d = S_PG_STRM;
      S_PG_STRM: begin
        if (beat) begin
          if (rresp != 2'b00)      state_d = S_ERR;
          else if (cnt_q == 6'd63) state_d = S_WAIT_COMP;
        end
      end
      S_WAIT_COMP: if (cd) state_d = cinc ? S_TBL_REQ : S_ZS_REQ;
      S_ZS_REQ:    if (pwm_ready) state_d = S_ZS_WAIT;
      S_ZS_WAIT:   if (zspg_updated) state_d = S_TBL_REQ;
      S_TBL_REQ:   if (pwm_ready) state_d = S_TBL_WAIT;
      S_TBL_WAIT: begin
        if (tbl_update_done) begin
          if (upd_sts == ST_COMP) begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end else if (upd_sts == ST_INCOMP &&
                       uncomp_head != uncomp_tail) begin
            state_d = S_POP;
          end else begin
            done_d  = 1'b1;
            fail_d  = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD:  if (!trigger) state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      sel_q      <= '0;
      way_q      <= '0;
      att_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pinc_q     <= 1'b0;
      psz_q      <= '0;
      rd_en_q    <= 1'b0;
      strm_q     <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      rdm_reset  <= 1'b0;
      comp_start <= 1'b0;
      zspg_req   <= 1'b0;
      zspg_way   <= '0;
      zspg_size  <= '0;
      tbl_update <= 1'b0;
      upd_att_id <= '0;
      upd_sts    <= '0;
      upd_ppa    <= '0;
      upd_lst_id <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      free_way   <= '0;
    end else begin
      state_q    <= state_d;
      done       <= done_d;
      rdm_reset  <= state_d == S_RDM_RST;
      comp_start <= state_d == S_RDM_RST;
      arvalid    <= (state_d == S_RD_REQ) || (state_d == S_PG_REQ);
      rd_en_q    <= (state_d == S_RD_WAIT) || (state_d == S_PG_STRM);
      strm_q     <= state_d == S_PG_STRM;
      zspg_req   <= (state_q == S_ZS_REQ) && pwm_ready;
      tbl_update <= (state_q == S_TBL_REQ) && pwm_ready;
      if (done_d) begin
        fail     <= fail_d;
        free_way <= fail_d ? '0 : way_q;
      end
      unique case (state_q)
        S_POP: begin
          if (uncomp_head != '0) begin
            id_q   <= uncomp_head;
            sel_q  <= tol_addr[5:3];
            araddr <= tol_addr & ~AW'(63);
            arlen  <= 8'd0;
          end
        end
        S_RD_WAIT: begin
          if (beat && rlast && rresp == 2'b00) begin
            way_q <= WW'(tol_word >> 32);
            att_q <= tol_word[15:0];
          end
        end
        S_RDM_RST: begin
          araddr <= {way_q, 12'h000};
          arlen  <= 8'd63;
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end
        S_PG_STRM: begin
          if (beat) cnt_q <= cnt_q + 6'd1;
          // compressor may finish before the last beat is accounted
          if (comp_done) begin
            pend_q <= 1'b1;
            pinc_q <= incompressible;
            psz_q  <= comp_size;
          end
        end
        S_WAIT_COMP: begin
          if (cd) begin
            pend_q <= 1'b0;
            if (cinc) begin
              upd_sts <= ST_INCOMP;
              upd_ppa <= {way_q, 12'h000};
            end else begin
              zspg_way  <= way_q;
              zspg_size <= csz;
            end
          end
        end
        S_ZS_WAIT: begin
          if (zspg_updated) begin
            upd_sts <= ST_COMP;
            upd_ppa <= zspg_cpage;
          end
        end
        S_TBL_REQ: begin
          if (pwm_ready) begin
            upd_att_id <= att_q;
            upd_lst_id <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_cmpresn_ctrl.sv
// Directed bench for hawk_cmpresn_ctrl: AXI, compressor and PWM
// responders driven by hand with hand-computed expectations.
module tb_hawk_cmpresn_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          trigger;
  logic [15:0]   uncomp_head, uncomp_tail;
  logic          arready, arvalid;
  logic [63:0]   araddr;
  logic [7:0]    arlen;
  logic          rvalid, rlast, rready;
  logic [1:0]    rresp;
  logic [511:0]  rdata;
  logic          rdfifo_full, rdm_reset, comp_start;
  logic          comp_done, incompressible;
  logic [13:0]   comp_size;
  logic          pwm_ready, zspg_req, zspg_updated;
  logic [51:0]   zspg_way, free_way;
  logic [13:0]   zspg_size;
  logic [63:0]   zspg_cpage, upd_ppa;
  logic          tbl_update, tbl_update_done;
  logic [15:0]   upd_att_id, upd_lst_id;
  logic [1:0]    upd_sts;
  logic          done, fail;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  hawk_cmpresn_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trigger(trigger),
    .uncomp_head(uncomp_head), .uncomp_tail(uncomp_tail),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rdata(rdata),
    .rready(rready), .rdfifo_full(rdfifo_full), .rdm_reset(rdm_reset),
    .comp_start(comp_start), .comp_done(comp_done),
    .incompressible(incompressible), .comp_size(comp_size),
    .pwm_ready(pwm_ready), .zspg_req(zspg_req), .zspg_way(zspg_way),
    .zspg_size(zspg_size), .zspg_updated(zspg_updated),
    .zspg_cpage(zspg_cpage), .tbl_update(tbl_update),
    .upd_att_id(upd_att_id), .upd_sts(upd_sts), .upd_ppa(upd_ppa),
    .upd_lst_id(upd_lst_id), .tbl_update_done(tbl_update_done),
    .done(done), .fail(fail), .free_way(free_way)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic sigsel(input int w);
    case (w)
      0:       return arvalid;
      1:       return rready;
      2:       return zspg_req;
      3:       return tbl_update;
      default: return done;
    endcase
  endfunction

  task automatic wait_out(input int w, input string tag);
    int i = 0;
    while (sigsel(w) !== 1'b1 && i < 500) begin
      @(negedge clk_i);
      i++;
    end
    if (sigsel(w) !== 1'b1) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic ar_hs(input string tag, input logic [63:0] a,
                       input logic [7:0] l, input int stall);
    bit st = 0;
    wait_out(0, tag);
    chk({tag, "_addr"}, araddr, a);
    chk({tag, "_len"}, 64'(arlen), 64'(l));
    repeat (stall) begin
      @(negedge clk_i);
      if (arvalid !== 1'b1 || araddr !== a || arlen !== l) st = 1;
    end
    if (stall > 0) chk({tag, "_stable"}, 64'(st), 0);
    arready = 1'b1;
    @(negedge clk_i);
    arready = 1'b0;
    chk({tag, "_drop"}, 64'(arvalid), 0);
  endtask

  task automatic tol_rsp(input logic [2:0] sel, input logic [63:0] word,
                         input logic [1:0] resp);
    wait_out(1, "tol_rready");
    rdata = '0;
    rdata[{sel, 6'b0} +: 64] = word;
    rvalid = 1'b1;
    rlast = 1'b1;
    rresp = resp;
    @(negedge clk_i);
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
  endtask

  task automatic stream(input bit tog, input bit cd_mid, input bit cinc);
    int n = 0;
    int cyc = 0;
    bit gate = 0;
    while (n < 64 && cyc < 400) begin
      rvalid = 1'b1;
      rlast = (n == 63);
      rdata = 512'(n);
      rdfifo_full = tog && (cyc % 3 == 1);
      comp_done = cd_mid && (cyc == 20);
      incompressible = cinc;
      #1;
      if (rready !== !rdfifo_full) gate = 1;
      if (rready) n++;
      @(negedge clk_i);
      cyc++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rdfifo_full = 1'b0;
    comp_done = 1'b0;
    chk("beats", 64'(n), 64);
    chk("rready_gate", 64'(gate), 0);
    chk("rready_end", 64'(rready), 0);
  endtask

  task automatic comp(input bit inc, input logic [13:0] sz);
    comp_done = 1'b1;
    incompressible = inc;
    comp_size = sz;
    @(negedge clk_i);
    comp_done = 1'b0;
  endtask

  task automatic zs(input logic [51:0] way, input logic [13:0] sz,
                    input logic [63:0] cp);
    wait_out(2, "zs_req");
    chk("zs_way", 64'(zspg_way), 64'(way));
    chk("zs_size", 64'(zspg_size), 64'(sz));
    zspg_cpage = cp;
    zspg_updated = 1'b1;
    @(negedge clk_i);
    zspg_updated = 1'b0;
    chk("zs_pulse", 64'(zspg_req), 0);
  endtask

  task automatic tbl(input logic [15:0] att, input logic [1:0] sts,
                     input logic [63:0] ppa, input logic [15:0] lst,
                     input logic [15:0] nhead);
    wait_out(3, "tbl_upd");
    chk("tbl_att", 64'(upd_att_id), 64'(att));
    chk("tbl_sts", 64'(upd_sts), 64'(sts));
    chk("tbl_ppa", upd_ppa, ppa);
    chk("tbl_lst", 64'(upd_lst_id), 64'(lst));
    tbl_update_done = 1'b1;
    uncomp_head = nhead;
    @(negedge clk_i);
    tbl_update_done = 1'b0;
  endtask

  task automatic fin(input bit f, input logic [51:0] way);
    wait_out(4, "done");
    chk("done_fail", 64'(fail), 64'(f));
    chk("done_way", 64'(free_way), 64'(way));
    @(negedge clk_i);
    chk("done_pulse", 64'(done), 0);
  endtask

  initial begin
    bit seen;
    trigger = 0; uncomp_head = 0; uncomp_tail = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
    rdfifo_full = 0; comp_done = 0; incompressible = 0; comp_size = 0;
    pwm_ready = 1; zspg_updated = 0; zspg_cpage = 0; tbl_update_done = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_done", 64'(done), 0);
    chk("rst_fail", 64'(fail), 0);
    chk("rst_arvalid", 64'(arvalid), 0);
    chk("rst_rready", 64'(rready), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_tbl", 64'(tbl_update), 0);
    rst_ni = 1;
    @(negedge clk_i);

    // compressible page, FIFO backpressure while streaming
    uncomp_head = 3; uncomp_tail = 5; trigger = 1;
    ar_hs("t1_tol", 64'h0, 8'd0, 0);
    tol_rsp(3'd2, {32'h12345, 16'h4, 16'h7}, 2'b00);
    chk("t1_rdm_reset", 64'(rdm_reset), 1);
    chk("t1_comp_start", 64'(comp_start), 1);
    ar_hs("t1_pg", 64'h12345000, 8'd63, 0);
    stream(1, 0, 0);
    comp(0, 14'd900);
    zs(52'h12345, 14'd900, 64'h80040);
    tbl(16'd7, 2'd3, 64'h80040, 16'd3, 16'd4);
    fin(0, 52'h12345);
    repeat (5) @(negedge clk_i);
    chk("t1_hold", 64'(arvalid), 0);
    trigger = 0;
    repeat (2) @(negedge clk_i);

    // empty list
    uncomp_head = 0; trigger = 1;
    repeat (2) @(negedge clk_i);
    chk("t2_done", 64'(done), 1);
    chk("t2_fail", 64'(fail), 1);
    chk("t2_arvalid", 64'(arvalid), 0);
    trigger = 0;
    repeat (2) @(negedge clk_i);

    // incompressible first entry, retry with next
    uncomp_head = 3; uncomp_tail = 5; trigger = 1;
    ar_hs("t3_tol", 64'h0, 8'd0, 0);
    tol_rsp(3'd2, {32'h12345, 16'h4, 16'h7}, 2'b00);
    ar_hs("t3_pg", 64'h12345000, 8'd63, 0);
    stream(0, 1, 1);
    tbl(16'd7, 2'd2, 64'h12345000, 16'd3, 16'd4);
    ar_hs("t3_tol2", 64'h0, 8'd0, 0);
    tol_rsp(3'd3, {32'h00abc, 16'h5, 16'h9}, 2'b00);
    ar_hs("t3_pg2", 64'h00abc000, 8'd63, 0);
    stream(0, 0, 0);
    comp(0, 14'd100);
    zs(52'habc, 14'd100, 64'h9000);
    tbl(16'd9, 2'd3, 64'h9000, 16'd4, 16'd4);
    fin(0, 52'habc);
    trigger = 0;
    repeat (2) @(negedge clk_i);

    // stalled AR, then error response on TOL read
    uncomp_head = 3; trigger = 1;
    ar_hs("t5_tol", 64'h0, 8'd0, 10);
    tol_rsp(3'd2, {32'h12345, 16'h4, 16'h7}, 2'b10);
    seen = 0;
    trigger = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (arvalid || done) seen = 1;
    end
    chk("t5_err_quiet", 64'(seen), 0);
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);

    // reset in the middle of the page burst
    uncomp_head = 3; trigger = 1;
    ar_hs("t6_tol", 64'h0, 8'd0, 0);
    tol_rsp(3'd2, {32'h12345, 16'h4, 16'h7}, 2'b00);
    ar_hs("t6_pg", 64'h12345000, 8'd63, 0);
    rvalid = 1;
    repeat (3) @(negedge clk_i);
    chk("t6_rready", 64'(rready), 1);
    rst_ni = 0;
    #1;
    chk("t6_rst_rready", 64'(rready), 0);
    chk("t6_rst_arvalid", 64'(arvalid), 0);
    rvalid = 0; trigger = 0;
    @(negedge clk_i);
    rst_ni = 1;
    repeat (3) @(negedge clk_i);
    chk("t6_idle", 64'(arvalid | done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
